bus_timer_slave: RTL and testbench

- Memory-mapped interval timer attached as an additional slave on the node's split-transaction request/response bus.
- Sits directly downstream of the main address decoder and consumes `enable[4]`, which decodes `address[27:24]==4'hB` (0x0B000000–0x0BFFFFFF).
- Services uncached register reads and writes, returns read data through the response-bus arbiter handshake, and raises a compare-match interrupt.

---
 rtl/bus_timer_slave_pkg.sv | 55 +++++
 rtl/bus_timer_slave_timer_core.sv | 115 +++++++++++
 rtl/bus_timer_slave.sv | 163 ++++++++++++++++
 tb/tb_bus_timer_slave.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_timer_slave_pkg.sv
// ---------------------------------------------------------------------------
// bus_timer_slave_pkg
// Shared definitions for the memory-mapped interval timer slave:
//   - request/response bus widths and command encodings
//   - node decoder slot for the timer (address[27:24] == 4'hB)
//   - timer register indices (address[3:2])
//   - ctrl_t layout of the CTRL register
//   - bus-side FSM state enum
// ---------------------------------------------------------------------------
package bus_timer_slave_pkg;

   localparam int DATA_WIDTH = 64;
   localparam int TAG_WIDTH  = 4;
   localparam int CMD_WIDTH  = 3;

   localparam logic [CMD_WIDTH-1:0] CMD_READ  = 3'd1;
   localparam logic [CMD_WIDTH-1:0] CMD_WRITE = 3'd2;

   localparam int         NUM_SLAVE    = 5;
   localparam int         TIMER_SLAVE  = 4;
   localparam logic [3:0] TIMER_DECODE = 4'hB;

   localparam logic [1:0] TIMER_IDX_CTRL    = 2'd0;
   localparam logic [1:0] TIMER_IDX_COUNT   = 2'd1;
   localparam logic [1:0] TIMER_IDX_COMPARE = 2'd2;
   localparam logic [1:0] TIMER_IDX_STATUS  = 2'd3;

   typedef struct packed {
      logic [7:0] div;
      logic       reload;
      logic       ie;
      logic       en;
   } ctrl_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_WDATA,
      ST_REQ
   } timer_state_t;

   // Timer slot of the node decoder's one-hot enable vector; the decoder
   // feeds it address[27:24].
   function automatic logic [NUM_SLAVE-1:0] timer_slot_enable(input logic [3:0] addrHi);
      logic [NUM_SLAVE-1:0] sel;
      sel = '0;
      sel[TIMER_SLAVE] = (addrHi == TIMER_DECODE);
      return sel;
   endfunction

   // CTRL as it reads back on the bus: en/ie/reload in [2:0], div in [15:8].
   function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
      return {16'd0, c.div, 5'd0, c.reload, c.ie, c.en};
   endfunction

endpackage

// File: rtl/bus_timer_slave_timer_core.sv
// ---------------------------------------------------------------------------
// bus_timer_slave_timer_core
// Prescaler, COUNT/COMPARE/STATUS registers and the interrupt of the timer.
// Ports:
//   clock, reset     system clock, asynchronous active-low reset
//   i_wr_en          one-cycle register write strobe
//   i_wr_idx         register index of the write
//   i_wr_data        write data
//   i_werr_set       sets STATUS.werr (abandoned bus write)
//   i_rd_idx         register index of the combinational read port
//   o_rd_data        read data for i_rd_idx
//   o_irq            registered STATUS.match & CTRL.ie
// ---------------------------------------------------------------------------
module bus_timer_slave_timer_core
   import bus_timer_slave_pkg::*;
#(
   parameter int PRESCALE_WIDTH = 8
)
(
   input  logic        clock,
   input  logic        reset,
   input  logic        i_wr_en,
   input  logic [1:0]  i_wr_idx,
   input  logic [31:0] i_wr_data,
   input  logic        i_werr_set,
   input  logic [1:0]  i_rd_idx,
   output logic [31:0] o_rd_data,
   output logic        o_irq
);

   ctrl_t                     r_ctrl;
   logic [PRESCALE_WIDTH-1:0] r_prescale;
   logic [31:0]               r_count;
   logic [31:0]               r_compare;
   logic                      r_match;
   logic                      r_werr;
   logic                      r_irq;

   logic w_wrCtrl;
   logic w_wrCount;
   logic w_wrCompare;
   logic w_wrStatus;
   logic w_run;
   logic w_tick;
   logic w_match;

   // Decode the write strobe and work out whether this cycle ticks. A CTRL
   // write that clears en freezes the prescaler in the same cycle, so the
   // run qualifier looks at the incoming en bit as well as the current one.
   always_comb begin
      w_wrCtrl    = i_wr_en && (i_wr_idx == TIMER_IDX_CTRL);
      w_wrCount   = i_wr_en && (i_wr_idx == TIMER_IDX_COUNT);
      w_wrCompare = i_wr_en && (i_wr_idx == TIMER_IDX_COMPARE);
      w_wrStatus  = i_wr_en && (i_wr_idx == TIMER_IDX_STATUS);
      w_run       = r_ctrl.en && !(w_wrCtrl && !i_wr_data[0]);
      w_tick      = w_run && (r_prescale == PRESCALE_WIDTH'(r_ctrl.div));
      w_match     = w_tick && (r_count == r_compare);
   end

   // Register update. A bus write to COUNT wins over the tick, and a new
   // match wins over a simultaneous W1C clear so no match is ever lost.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_ctrl     <= '0;
         r_prescale <= '0;
         r_count    <= '0;
         r_compare  <= '0;
         r_match    <= 1'b0;
         r_werr     <= 1'b0;
         r_irq      <= 1'b0;
      end else begin
         if (w_wrCtrl) begin
            r_ctrl <= '{div: i_wr_data[15:8], reload: i_wr_data[2],
                        ie: i_wr_data[1], en: i_wr_data[0]};
         end
         if (w_run) begin
            r_prescale <= w_tick ? '0 : r_prescale + PRESCALE_WIDTH'(1);
         end
         if (w_wrCount) begin
            r_count <= i_wr_data;
         end else if (w_tick) begin
            r_count <= (w_match && r_ctrl.reload) ? 32'd0 : r_count + 32'd1;
         end
         if (w_wrCompare) begin
            r_compare <= i_wr_data;
         end
         if (w_match) begin
            r_match <= 1'b1;
         end else if (w_wrStatus && i_wr_data[0]) begin
            r_match <= 1'b0;
         end
         if (i_werr_set) begin
            r_werr <= 1'b1;
         end else if (w_wrStatus && i_wr_data[1]) begin
            r_werr <= 1'b0;
         end
         r_irq <= r_match && r_ctrl.ie;
      end
   end

   // Combinational read port; the bus FSM snapshots it at acceptance.
   always_comb begin
      o_rd_data = 32'd0;
      case (i_rd_idx)
         TIMER_IDX_CTRL:    o_rd_data = ctrl_to_word(r_ctrl);
         TIMER_IDX_COUNT:   o_rd_data = r_count;
         TIMER_IDX_COMPARE: o_rd_data = r_compare;
         TIMER_IDX_STATUS:  o_rd_data = {30'd0, r_werr, r_match};
         default:           o_rd_data = 32'd0;
      endcase
   end

   assign o_irq = r_irq;

endmodule

// File: rtl/bus_timer_slave.sv
// ---------------------------------------------------------------------------
// bus_timer_slave
// Interval timer slave on the split-transaction request/response bus.
// Reads return a snapshot through the response-bus arbiter; writes take
// their data from the snooped response bus when the latched tag reappears.
// Ports:
//   clock, reset                 system clock, asynchronous active-low reset
//   enable                       decoder select (address[27:24] == 4'hB)
//   req_address/command/tag      request bus fields
//   req_valid, req_inhibit       request qualifiers
//   rsp_data_in, rsp_tag_in      snooped response bus (write data)
//   response_data/tag            read data and tag, driven while response_oe
//   response_oe                  response bus drive enable
//   response_breq/bhold/bgnt     response bus arbitration (bhold tied 0)
//   nack                         wired-OR negative acknowledge
//   irq                          timer interrupt
// ---------------------------------------------------------------------------
module bus_timer_slave
   import bus_timer_slave_pkg::*;
#(
   parameter int PRESCALE_WIDTH = 8,
   parameter int WDATA_TIMEOUT  = 255
)
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [31:0]           req_address,
   input  logic [CMD_WIDTH-1:0]  req_command,
   input  logic [TAG_WIDTH-1:0]  req_tag,
   input  logic                  req_valid,
   input  logic                  req_inhibit,
   input  logic [DATA_WIDTH-1:0] rsp_data_in,
   input  logic [TAG_WIDTH-1:0]  rsp_tag_in,
   output logic [DATA_WIDTH-1:0] response_data,
   output logic [TAG_WIDTH-1:0]  response_tag,
   output logic                  response_oe,
   output logic                  response_breq,
   output logic                  response_bhold,
   input  logic                  response_bgnt,
   output logic                  nack,
   output logic                  irq
);

   localparam int               TMO_W    = $clog2(WDATA_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(WDATA_TIMEOUT - 1);

   timer_state_t         r_state;
   timer_state_t         w_nextState;
   logic [TAG_WIDTH-1:0] r_tag;
   logic [1:0]           r_idx;
   logic [31:0]          r_rdata;
   logic [TMO_W-1:0]     r_tmo;

   logic        w_select;
   logic        w_cmdOk;
   logic        w_acceptRd;
   logic        w_acceptWr;
   logic        w_tagHit;
   logic        w_timeout;
   logic        w_wrEn;
   logic        w_werrSet;
   logic [31:0] w_rdData;
   logic        w_unused;

   assign w_select  = req_valid && enable && !req_inhibit;
   assign w_cmdOk   = (req_command == CMD_READ) || (req_command == CMD_WRITE);
   assign w_tagHit  = (rsp_tag_in == r_tag);
   assign w_timeout = (r_tmo == TMO_LAST);

   assign response_bhold = 1'b0;
   assign w_unused = ^{req_address[31:4], req_address[1:0], rsp_data_in[DATA_WIDTH-1:32]};

   // Bus FSM next state and outputs. nack is combinational in the request
   // cycle and is gated by reset so every output reads 0 while in reset.
   always_comb begin
      w_nextState   = r_state;
      response_breq = 1'b0;
      response_oe   = 1'b0;
      response_data = '0;
      response_tag  = '0;
      nack          = 1'b0;
      w_acceptRd    = 1'b0;
      w_acceptWr    = 1'b0;
      w_wrEn        = 1'b0;
      w_werrSet     = 1'b0;
      if (w_select && ((r_state != ST_IDLE) || !w_cmdOk)) begin
         nack = reset;
      end
      case (r_state)
         ST_IDLE: begin
            if (w_select && (req_command == CMD_READ)) begin
               w_acceptRd  = 1'b1;
               w_nextState = ST_REQ;
            end else if (w_select && (req_command == CMD_WRITE)) begin
               w_acceptWr  = 1'b1;
               w_nextState = ST_WAIT_WDATA;
            end
         end
         ST_WAIT_WDATA: begin
            if (w_tagHit) begin
               w_wrEn      = 1'b1;
               w_nextState = ST_IDLE;
            end else if (w_timeout) begin
               w_werrSet   = 1'b1;
               w_nextState = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (response_bgnt) begin
               response_oe   = 1'b1;
               response_data = DATA_WIDTH'(r_rdata);
               response_tag  = r_tag;
               w_nextState   = ST_IDLE;
            end else begin
               response_breq = 1'b1;
            end
         end
         default: w_nextState = ST_IDLE;
      endcase
   end

   // State register plus the per-transaction latches: tag and index at
   // acceptance, the read snapshot, and the write-data wait counter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_tag   <= '0;
         r_idx   <= '0;
         r_rdata <= '0;
         r_tmo   <= '0;
      end else begin
         r_state <= w_nextState;
         if (w_acceptRd || w_acceptWr) begin
            r_tag <= req_tag;
            r_idx <= req_address[3:2];
         end
         if (w_acceptRd) begin
            r_rdata <= w_rdData;
         end
         if (w_acceptWr) begin
            r_tmo <= '0;
         end else if (r_state == ST_WAIT_WDATA) begin
            r_tmo <= r_tmo + TMO_W'(1);
         end
      end
   end

   bus_timer_slave_timer_core #(
      .PRESCALE_WIDTH (PRESCALE_WIDTH)
   ) u_core (
      .clock      (clock),
      .reset      (reset),
      .i_wr_en    (w_wrEn),
      .i_wr_idx   (r_idx),
      .i_wr_data  (rsp_data_in[31:0]),
      .i_werr_set (w_werrSet),
      .i_rd_idx   (req_address[3:2]),
      .o_rd_data  (w_rdData),
      .o_irq      (irq)
   );

endmodule

// File: tb/tb_bus_timer_slave.sv
// ---------------------------------------------------------------------------
// tb_bus_timer_slave
// Directed bench for bus_timer_slave: reset, write/match/irq timing, read
// with delayed grant, busy and bad-command nack, back-to-back requests,
// write-data timeout, inhibit, async reset mid-read, prescaler wrap.
// ---------------------------------------------------------------------------
module tb_bus_timer_slave;
   import bus_timer_slave_pkg::*;

   localparam logic [TAG_WIDTH-1:0] IDLE_TAG = 4'hE;

   logic                  clock;
   logic                  reset;
   logic                  enable;
   logic [31:0]           req_address;
   logic [CMD_WIDTH-1:0]  req_command;
   logic [TAG_WIDTH-1:0]  req_tag;
   logic                  req_valid;
   logic                  req_inhibit;
   logic [DATA_WIDTH-1:0] rsp_data_in;
   logic [TAG_WIDTH-1:0]  rsp_tag_in;
   logic [DATA_WIDTH-1:0] response_data;
   logic [TAG_WIDTH-1:0]  response_tag;
   logic                  response_oe;
   logic                  response_breq;
   logic                  response_bhold;
   logic                  response_bgnt;
   logic                  nack;
   logic                  irq;

   int vecCount  = 0;
   int missCount = 0;

   bus_timer_slave #(
      .PRESCALE_WIDTH (8),
      .WDATA_TIMEOUT  (255)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .enable         (enable),
      .req_address    (req_address),
      .req_command    (req_command),
      .req_tag        (req_tag),
      .req_valid      (req_valid),
      .req_inhibit    (req_inhibit),
      .rsp_data_in    (rsp_data_in),
      .rsp_tag_in     (rsp_tag_in),
      .response_data  (response_data),
      .response_tag   (response_tag),
      .response_oe    (response_oe),
      .response_breq  (response_breq),
      .response_bhold (response_bhold),
      .response_bgnt  (response_bgnt),
      .nack           (nack),
      .irq            (irq)
   );

   // Free-running clock, period 10.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Hard stop in case the run never reaches its summary.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_bus();
      req_valid   = 1'b0;
      enable      = 1'b0;
      req_inhibit = 1'b0;
      req_command = '0;
      req_tag     = '0;
      req_address = '0;
   endtask

   task automatic drive_req(input logic [CMD_WIDTH-1:0] cmd, input logic [1:0] idx, input logic [3:0] tag);
      req_valid   = 1'b1;
      enable      = 1'b1;
      req_inhibit = 1'b0;
      req_command = cmd;
      req_tag     = tag;
      req_address = {4'h0, 4'hB, 20'h0, idx, 2'b00};
   endtask

   // Write: request in cycle C0, data tag shows up dataDelay cycles later;
   // returns one tick after the edge that performs the register write.
   task automatic bus_write(input logic [1:0] idx, input logic [31:0] data, input logic [3:0] tag, input int dataDelay);
      drive_req(CMD_WRITE, idx, tag);
      next_cycle();
      idle_bus();
      repeat (dataDelay - 1) next_cycle();
      rsp_tag_in  = tag;
      rsp_data_in = {32'hA5A5_A5A5, data};
      next_cycle();
      rsp_tag_in  = IDLE_TAG;
      rsp_data_in = '0;
   endtask

   // Read with a grant delay; returns observations for the caller to judge.
   task automatic bus_read(input logic [1:0] idx, input logic [3:0] tag, input int gntDelay, input bit pokeBusy,
                           output logic nackAtReq, output logic nackBusy, output int breqCycles,
                           output logic oeSeen, output logic breqAtGnt, output logic [DATA_WIDTH-1:0] dataOut,
                           output logic [3:0] tagOut, output logic busyAfter);
      drive_req(CMD_READ, idx, tag);
      #2;
      nackAtReq = nack;
      next_cycle();
      idle_bus();
      nackBusy   = 1'b0;
      breqCycles = 0;
      for (int i = 0; i < gntDelay; i++) begin
         if (pokeBusy && (i == 0)) drive_req(CMD_WRITE, TIMER_IDX_CTRL, 4'h9);
         @(negedge clock);
         if (pokeBusy && (i == 0)) nackBusy = nack;
         if (response_breq && !response_oe) breqCycles++;
         next_cycle();
         idle_bus();
      end
      response_bgnt = 1'b1;
      @(negedge clock);
      oeSeen    = response_oe;
      breqAtGnt = response_breq;
      dataOut   = response_data;
      tagOut    = response_tag;
      next_cycle();
      response_bgnt = 1'b0;
      #1;
      busyAfter = response_oe | response_breq;
   endtask

   task automatic test_reset();
      logic nr, nb, oe, ba, bz;
      int bc;
      logic [DATA_WIDTH-1:0] d;
      logic [3:0] t;
      reset = 1'b0;
      idle_bus();
      response_bgnt = 1'b0;
      rsp_tag_in    = IDLE_TAG;
      rsp_data_in   = '0;
      repeat (2) next_cycle();
      vecCount++; if (response_breq !== 1'b0) begin missCount++; $display("[TB] FAIL reset_breq: got %b expected 0", response_breq); end
      vecCount++; if (response_oe !== 1'b0) begin missCount++; $display("[TB] FAIL reset_oe: got %b expected 0", response_oe); end
      vecCount++; if (irq !== 1'b0) begin missCount++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
      vecCount++; if (nack !== 1'b0) begin missCount++; $display("[TB] FAIL reset_nack: got %b expected 0", nack); end
      vecCount++; if (response_bhold !== 1'b0) begin missCount++; $display("[TB] FAIL reset_bhold: got %b expected 0", response_bhold); end
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus_read(2'(i), 4'(i), 1, 1'b0, nr, nb, bc, oe, ba, d, t, bz);
         vecCount++; if (d !== 64'd0) begin missCount++; $display("[TB] FAIL reset_reg%0d: got %h expected 0", i, d); end
         vecCount++; if (t !== 4'(i)) begin missCount++; $display("[TB] FAIL reset_tag%0d: got %h expected %h", i, t, i); end
      end
   endtask

   task automatic test_write_match();
      logic nr, nb, oe, ba, bz;
      int bc;
      logic [DATA_WIDTH-1:0] d;
      logic [3:0] t;
      bus_write(TIMER_IDX_COMPARE, 32'd5, 4'd3, 2);
      bus_write(TIMER_IDX_CTRL, 32'h0000_0007, 4'd4, 1);
      for (int k = 1; k <= 7; k++) begin
         next_cycle();
         if (k == 5) begin
            vecCount++; if (dut.u_core.r_count !== 32'd5) begin missCount++; $display("[TB] FAIL match_count5: got %h expected 5", dut.u_core.r_count); end
            vecCount++; if (dut.u_core.r_match !== 1'b0) begin missCount++; $display("[TB] FAIL match_early: got %b expected 0", dut.u_core.r_match); end
         end
         if (k == 6) begin
            vecCount++; if (dut.u_core.r_count !== 32'd0) begin missCount++; $display("[TB] FAIL match_reload: got %h expected 0", dut.u_core.r_count); end
            vecCount++; if (dut.u_core.r_match !== 1'b1) begin missCount++; $display("[TB] FAIL match_set: got %b expected 1", dut.u_core.r_match); end
            vecCount++; if (irq !== 1'b0) begin missCount++; $display("[TB] FAIL irq_latency: got %b expected 0", irq); end
         end
         if (k == 7) begin
            vecCount++; if (irq !== 1'b1) begin missCount++; $display("[TB] FAIL irq_rise: got %b expected 1", irq); end
         end
      end
      bus_write(TIMER_IDX_CTRL, 32'h0000_0000, 4'd4, 1);
      bus_write(TIMER_IDX_STATUS, 32'h0000_0001, 4'd4, 1);
      bus_read(TIMER_IDX_STATUS, 4'd1, 1, 1'b0, nr, nb, bc, oe, ba, d, t, bz);
      vecCount++; if (d !== 64'd0) begin missCount++; $display("[TB] FAIL match_w1c: got %h expected 0", d); end
      vecCount++; if (irq !== 1'b0) begin missCount++; $display("[TB] FAIL irq_clear: got %b expected 0", irq); end
   endtask

   task automatic test_read_grant_delay();
      logic nr, nb, oe, ba, bz;
      int bc;
      logic [DATA_WIDTH-1:0] d;
      logic [3:0] t;
      bus_write(TIMER_IDX_COUNT, 32'h0000_1234, 4'd5, 1);
      bus_read(TIMER_IDX_COUNT, 4'd7, 4, 1'b0, nr, nb, bc, oe, ba, d, t, bz);
      vecCount++; if (nr !== 1'b0) begin missCount++; $display("[TB] FAIL rd_nack: got %b expected 0", nr); end
      vecCount++; if (bc !== 4) begin missCount++; $display("[TB] FAIL rd_breq_cycles: got %0d expected 4", bc); end
      vecCount++; if (oe !== 1'b1) begin missCount++; $display("[TB] FAIL rd_oe: got %b expected 1", oe); end
      vecCount++; if (ba !== 1'b0) begin missCount++; $display("[TB] FAIL rd_breq_at_gnt: got %b expected 0", ba); end
      vecCount++; if (t !== 4'd7) begin missCount++; $display("[TB] FAIL rd_tag: got %h expected 7", t); end
      vecCount++; if (d !== 64'h0000_0000_0000_1234) begin missCount++; $display("[TB] FAIL rd_data: got %h expected 1234", d); end
      vecCount++; if (bz !== 1'b0) begin missCount++; $display("[TB] FAIL rd_single_beat: got %b expected 0", bz); end
   endtask

   task automatic test_busy_and_bad_cmd();
      logic nr, nb, oe, ba, bz;
      int bc;
      logic [DATA_WIDTH-1:0] d;
      logic [3:0] t;
      bus_read(TIMER_IDX_COMPARE, 4'd2, 3, 1'b1, nr, nb, bc, oe, ba, d, t, bz);
      vecCount++; if (nb !== 1'b1) begin missCount++; $display("[TB] FAIL busy_nack: got %b expected 1", nb); end
      vecCount++; if (oe !== 1'b1) begin missCount++; $display("[TB] FAIL busy_oe: got %b expected 1", oe); end
      vecCount++; if (d !== 64'd5) begin missCount++; $display("[TB] FAIL busy_data: got %h expected 5", d); end
      vecCount++; if (t !== 4'd2) begin missCount++; $display("[TB] FAIL busy_tag: got %h expected 2", t); end
      drive_req(3'd5, TIMER_IDX_COUNT, 4'd8);
      #2;
      vecCount++; if (nack !== 1'b1) begin missCount++; $display("[TB] FAIL badcmd_nack: got %b expected 1", nack); end
      next_cycle();
      idle_bus();
      #1;
      vecCount++; if (dut.r_state !== ST_IDLE) begin missCount++; $display("[TB] FAIL badcmd_state: got %0d expected %0d", dut.r_state, ST_IDLE); end
      vecCount++; if (response_breq !== 1'b0) begin missCount++; $display("[TB] FAIL badcmd_breq: got %b expected 0", response_breq); end
   endtask

   task automatic test_back_to_back();
      logic nr, nb, oe, ba, bz;
      int bc;
      logic [DATA_WIDTH-1:0] d;
      logic [3:0] t;
      bus_read(TIMER_IDX_CTRL, 4'd1, 0, 1'b0, nr, nb, bc, oe, ba, d, t, bz);
      vecCount++; if (d !== 64'd0) begin missCount++; $display("[TB] FAIL b2b_first_data: got %h expected 0", d); end
      bus_read(TIMER_IDX_COMPARE, 4'd6, 0, 1'b0, nr, nb, bc, oe, ba, d, t, bz);
      vecCount++; if (nr !== 1'b0) begin missCount++; $display("[TB] FAIL b2b_nack: got %b expected 0", nr); end
      vecCount++; if (oe !== 1'b1) begin missCount++; $display("[TB] FAIL b2b_oe: got %b expected 1", oe); end
      vecCount++; if (d !== 64'd5) begin missCount++; $display("[TB] FAIL b2b_data: got %h expected 5", d); end
      vecCount++; if (t !== 4'd6) begin missCount++; $display("[TB] FAIL b2b_tag: got %h expected 6", t); end
   endtask

   task automatic test_write_timeout();
      logic nr, nb, oe, ba, bz;
      int bc;
      logic [DATA_WIDTH-1:0] d;
      logic [3:0] t;
      drive_req(CMD_WRITE, TIMER_IDX_COMPARE, 4'd9);
      next_cycle();
      idle_bus();
      repeat (254) next_cycle();
      vecCount++; if (dut.r_state !== ST_WAIT_WDATA) begin missCount++; $display("[TB] FAIL tmo_still_wait: got %0d expected %0d", dut.r_state, ST_WAIT_WDATA); end
      next_cycle();
      vecCount++; if (dut.r_state !== ST_IDLE) begin missCount++; $display("[TB] FAIL tmo_idle: got %0d expected %0d", dut.r_state, ST_IDLE); end
      bus_read(TIMER_IDX_COMPARE, 4'd1, 1, 1'b0, nr, nb, bc, oe, ba, d, t, bz);
      vecCount++; if (d !== 64'd5) begin missCount++; $display("[TB] FAIL tmo_unchanged: got %h expected 5", d); end
      bus_read(TIMER_IDX_STATUS, 4'd1, 1, 1'b0, nr, nb, bc, oe, ba, d, t, bz);
      vecCount++; if (d !== 64'd2) begin missCount++; $display("[TB] FAIL tmo_werr: got %h expected 2", d); end
      bus_write(TIMER_IDX_STATUS, 32'h0000_0002, 4'd10, 1);
      bus_read(TIMER_IDX_STATUS, 4'd1, 1, 1'b0, nr, nb, bc, oe, ba, d, t, bz);
      vecCount++; if (d !== 64'd0) begin missCount++; $display("[TB] FAIL werr_w1c: got %h expected 0", d); end
   endtask

   task automatic test_inhibit_and_reset();
      drive_req(CMD_READ, TIMER_IDX_COUNT, 4'd3);
      req_inhibit = 1'b1;
      #2;
      vecCount++; if (nack !== 1'b0) begin missCount++; $display("[TB] FAIL inhibit_nack: got %b expected 0", nack); end
      next_cycle();
      idle_bus();
      #1;
      vecCount++; if (response_breq !== 1'b0) begin missCount++; $display("[TB] FAIL inhibit_breq: got %b expected 0", response_breq); end
      bus_write(TIMER_IDX_COMPARE, 32'h0000_1234, 4'd11, 1);
      bus_write(TIMER_IDX_CTRL, 32'h0000_0003, 4'd11, 1);
      repeat (3) next_cycle();
      vecCount++; if (irq !== 1'b1) begin missCount++; $display("[TB] FAIL pre_reset_irq: got %b expected 1", irq); end
      drive_req(CMD_READ, TIMER_IDX_COUNT, 4'd12);
      next_cycle();
      idle_bus();
      #1;
      vecCount++; if (response_breq !== 1'b1) begin missCount++; $display("[TB] FAIL pre_reset_breq: got %b expected 1", response_breq); end
      reset = 1'b0;
      #1;
      vecCount++; if (response_breq !== 1'b0) begin missCount++; $display("[TB] FAIL async_breq: got %b expected 0", response_breq); end
      vecCount++; if (response_oe !== 1'b0) begin missCount++; $display("[TB] FAIL async_oe: got %b expected 0", response_oe); end
      vecCount++; if (irq !== 1'b0) begin missCount++; $display("[TB] FAIL async_irq: got %b expected 0", irq); end
      vecCount++; if (dut.u_core.r_count !== 32'd0) begin missCount++; $display("[TB] FAIL async_count: got %h expected 0", dut.u_core.r_count); end
      repeat (2) next_cycle();
      reset = 1'b1;
      next_cycle();
   endtask

   task automatic test_prescaler_wrap();
      bus_write(TIMER_IDX_COMPARE, 32'd1, 4'd13, 1);
      bus_write(TIMER_IDX_COUNT, 32'hFFFF_FFFF, 4'd13, 1);
      bus_write(TIMER_IDX_CTRL, 32'h0000_0301, 4'd13, 1);
      for (int k = 1; k <= 12; k++) begin
         next_cycle();
         if (k == 3) begin
            vecCount++; if (dut.u_core.r_count !== 32'hFFFF_FFFF) begin missCount++; $display("[TB] FAIL psc_hold: got %h expected ffffffff", dut.u_core.r_count); end
         end
         if (k == 4) begin
            vecCount++; if (dut.u_core.r_count !== 32'd0) begin missCount++; $display("[TB] FAIL psc_wrap: got %h expected 0", dut.u_core.r_count); end
            vecCount++; if (dut.u_core.r_match !== 1'b0) begin missCount++; $display("[TB] FAIL psc_no_match4: got %b expected 0", dut.u_core.r_match); end
         end
         if (k == 8) begin
            vecCount++; if (dut.u_core.r_count !== 32'd1) begin missCount++; $display("[TB] FAIL psc_count1: got %h expected 1", dut.u_core.r_count); end
            vecCount++; if (dut.u_core.r_match !== 1'b0) begin missCount++; $display("[TB] FAIL psc_no_match8: got %b expected 0", dut.u_core.r_match); end
         end
         if (k == 11) begin
            vecCount++; if (dut.u_core.r_match !== 1'b0) begin missCount++; $display("[TB] FAIL psc_no_match11: got %b expected 0", dut.u_core.r_match); end
         end
         if (k == 12) begin
            vecCount++; if (dut.u_core.r_match !== 1'b1) begin missCount++; $display("[TB] FAIL psc_match: got %b expected 1", dut.u_core.r_match); end
            vecCount++; if (dut.u_core.r_count !== 32'd2) begin missCount++; $display("[TB] FAIL psc_count2: got %h expected 2", dut.u_core.r_count); end
         end
      end
   endtask

   initial begin
      $display("[TB] bus_timer_slave directed bench start");
      test_reset();
      test_write_match();
      test_read_grant_delay();
      test_busy_and_bad_cmd();
      test_back_to_back();
      test_write_timeout();
      test_inhibit_and_reset();
      test_prescaler_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
